seq_signed_mult: RTL



---
 rtl/seq_signed_mult.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_signed_mult.sv
// Sequential shift-add multiplier for two WIDTH-bit two's-complement operands, one iteration per clock.
// Optional build macro SEQ_MULT_UNSIGNED_MODE_EN adds a signed_i port selecting signed/unsigned operation.
module seq_signed_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
`ifdef SEQ_MULT_UNSIGNED_MODE_EN
  input  logic               signed_i,
`endif
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               x_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic             sgn;

  logic             last_iter;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

`ifdef SEQ_MULT_UNSIGNED_MODE_EN
  logic sgn_q;
  assign sgn = sgn_q;
`else
  assign sgn = 1'b1;
`endif

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // One add/subtract step followed by the arithmetic right shift of {X,A,B}.
  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    addend = {sgn & s_q[WIDTH-1], s_q};
    if (last_iter && sgn) begin
      addend = (~addend) + (WIDTH+1)'(1);
    end
    sum = {x_q, a_q};
    if (b_q[0]) begin
      sum = {sgn & a_q[WIDTH-1], a_q} + addend;
    end
    // Unsigned mode: the carry enters A's MSB, then X is cleared.
    x_d = sgn & sum[WIDTH];
    a_d = {sum[WIDTH], sum[WIDTH-1:1]};
    b_d = {sum[0], b_q[WIDTH-1:1]};
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_MULT_UNSIGNED_MODE_EN
      sgn_q   <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= multiplier_i;
            s_q     <= multiplicand_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef SEQ_MULT_UNSIGNED_MODE_EN
            sgn_q   <= signed_i;
`endif
          end
        end
        RUN: begin
          x_q   <= x_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // A held Start must not retrigger; wait for release.
          if (!start_i) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign product_o = {a_q, b_q};
  assign x_o       = x_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
